// File: rtl/if_pkg.sv
// Shared types for the prefetching fetch stage: redirect source encoding and
// the priority rule that picks one redirect when several are requested.
package if_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CALL   = 2'd1,
    BRANCH = 2'd2,
    RET    = 2'd3
  } redirect_src_e;

  function automatic redirect_src_e sel_redirect(input logic call_i,
                                                 input logic branch_i,
                                                 input logic ret_i);
    redirect_src_e src;
    if (call_i) begin
      src = CALL;
    end else if (branch_i) begin
      src = BRANCH;
    end else if (ret_i) begin
      src = RET;
    end else begin
      src = NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with clear; pointers wrap mod DEPTH (power of 2), clear
// has priority over push and pop.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  always_comb begin
    empty  = (r_count == CW'(0));
    full   = (r_count == CW'(DEPTH));
    w_push = push && !full;
    w_pop  = pop && !empty;
    dout   = r_mem[r_rd];
    count  = r_count;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  if_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .full  (full)
  );

endmodule

// File: rtl/if_fifo_chk.sv
// Protocol checker for the prefetch queue: a push must never meet a full queue
// unless the same cycle clears it.
module if_fifo_chk (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic push,
  input logic full
);

  // Overflow is prevented upstream by the issue credit check.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch stage: holds the fetch PC, issues one read per cycle to a
// 1-cycle memory and buffers {instr, PC+1} in a queue toward decode.
module if_prefetch
  import if_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   call,
  input  logic                   branch,
  input  logic                   ret,
  input  logic [PC_W-1:0]        pc_call,
  input  logic [PC_W-1:0]        pc_branch,
  input  logic [PC_W-1:0]        pc_ret,
  output logic [PC_W-1:0]        im_addr,
  output logic                   im_rd_en,
  input  logic [INSTR_W-1:0]     im_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc_inc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_inc;
  } entry_t;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_inc;
  logic            r_inflight;

  redirect_src_e   w_src;
  logic            w_redirect;
  logic [PC_W-1:0] w_target;
  logic [CW:0]     w_occ;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  entry_t          w_din;
  entry_t          w_dout;

  // Credit check counts the outstanding read but not a same-cycle pop.
  always_comb begin
    w_src      = sel_redirect(call, branch, ret);
    w_redirect = (w_src != NONE);
    case (w_src)
      CALL:    w_target = pc_call;
      BRANCH:  w_target = pc_branch;
      RET:     w_target = pc_ret;
      default: w_target = r_pc;
    endcase
    w_occ      = {1'b0, count} + {{CW{1'b0}}, r_inflight};
    w_issue    = !rst && !w_redirect && (w_occ < (CW + 1)'(DEPTH));
    w_push     = r_inflight && !w_redirect && !rst;
    w_pop      = !w_empty && out_ready;
    w_din      = '{instr: im_instr, pc_inc: r_pc_inc};
    im_addr    = r_pc;
    im_rd_en   = w_issue;
    out_valid  = !w_empty;
    out_instr  = w_dout.instr;
    out_pc_inc = w_dout.pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc_inc   <= {PC_W{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc     <= r_pc + PC_W'(1);
        r_pc_inc <= r_pc + PC_W'(1);
      end else begin
        r_pc <= r_pc;
      end
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (w_redirect),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (count),
    .empty (w_empty),
    .full  (w_full)
  );

endmodule
